// File: rtl/msg_blocker_if.sv
// Bundle of the message, block, chaining-value and digest handshakes of msg_blocker.
// The master modport is the feeding side. The slave modport is the blocker.
interface msg_blocker_if #(
  parameter int W  = 32,
  parameter int IB = 1
);
  logic                        start;
  logic [8*IB-1:0]             in_data;
  logic [$clog2(IB+1)-1:0]     in_nbytes;
  logic                        in_valid;
  logic                        in_ready;
  logic                        in_last;
  logic                        blk_valid;
  logic                        blk_ready;
  logic [16*W-1:0]             m_out;
  logic [2*W-1:0]              t_out;
  logic                        f_out;
  logic [8*W-1:0]              h_in;
  logic                        h_valid;
  logic [7:0]                  out_data;
  logic                        out_valid;
  logic                        out_ready;
  logic                        out_last;
  logic                        busy;

  modport master (
    output start, in_data, in_nbytes, in_valid, in_last, blk_ready, h_in, h_valid, out_ready,
    input  in_ready, blk_valid, m_out, t_out, f_out, out_data, out_valid, out_last, busy
  );

  modport slave (
    input  start, in_data, in_nbytes, in_valid, in_last, blk_ready, h_in, h_valid, out_ready,
    output in_ready, blk_valid, m_out, t_out, f_out, out_data, out_valid, out_last, busy
  );
endinterface

// File: rtl/msg_blocker.sv
// Packs message bytes into 2*W-byte blocks for a compressor and streams the final chaining value out.
// Blocks are emitted the cycle after they fill. start aborts and restarts from any state.
module msg_blocker #(
  parameter int W       = 32,
  parameter int IB      = 1,
  parameter int OUT_LEN = W
) (
  input  logic          clk,
  input  logic          rst_n,
  msg_blocker_if.slave  bus
);
  localparam int BB  = 2 * W;
  localparam int CW  = $clog2(BB + 1);
  localparam int IW  = (OUT_LEN > 1) ? $clog2(OUT_LEN) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FILL   = 3'd1;
  localparam logic [2:0] S_EMIT   = 3'd2;
  localparam logic [2:0] S_WAIT_H = 3'd3;
  localparam logic [2:0] S_OUT    = 3'd4;

  logic [2:0]      state_q, state_d;
  logic [8*BB-1:0] blk_q, blk_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2*W-1:0]  t_q, t_d;
  logic            f_q, f_d;
  logic [8*W-1:0]  h_q, h_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [1:0]      sync_q;
  logic [CW:0]     cnt_sum;
  logic            idx_last;

  assign cnt_sum  = {1'b0, cnt_q} + (CW+1)'(bus.in_nbytes);
  assign idx_last = (idx_q == IW'(OUT_LEN - 1));

  always_comb begin
    state_d = state_q;
    blk_d   = blk_q;
    cnt_d   = cnt_q;
    t_d     = t_q;
    f_d     = f_q;
    h_d     = h_q;
    idx_d   = idx_q;
    if (bus.start) begin
      state_d = S_FILL;
      blk_d   = '0;
      cnt_d   = '0;
      t_d     = '0;
      f_d     = 1'b0;
    end else begin
      case (state_q)
        S_FILL: begin
          if (bus.in_valid) begin
            // Bytes past the end of the block (only possible with short mid-message beats) are dropped.
            for (int k = 0; k < IB; k++) begin
              if (k < int'(bus.in_nbytes) && (int'(cnt_q) + k) < BB)
                blk_d[8*(int'(cnt_q)+k) +: 8] = bus.in_data[8*k +: 8];
            end
            cnt_d = cnt_sum[CW-1:0];
            t_d   = t_q + (2*W)'(bus.in_nbytes);
            f_d   = bus.in_last;
            if (bus.in_last || cnt_sum >= (CW+1)'(BB))
              state_d = S_EMIT;
          end
        end
        S_EMIT: begin
          if (bus.blk_ready) begin
            blk_d   = '0;
            cnt_d   = '0;
            state_d = f_q ? S_WAIT_H : S_FILL;
          end
        end
        S_WAIT_H: begin
          if (bus.h_valid) begin
            h_d     = bus.h_in;
            idx_d   = '0;
            state_d = S_OUT;
          end
        end
        S_OUT: begin
          if (bus.out_ready) begin
            if (idx_last) state_d = S_IDLE;
            else          idx_d   = idx_q + 1'b1;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  // Reset release is retimed so the first state change lands on the third edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b00;
    else        sync_q <= {sync_q[0], 1'b1};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      blk_q   <= '0;
      cnt_q   <= '0;
      t_q     <= '0;
      f_q     <= 1'b0;
      h_q     <= '0;
      idx_q   <= '0;
    end else if (sync_q[1]) begin
      state_q <= state_d;
      blk_q   <= blk_d;
      cnt_q   <= cnt_d;
      t_q     <= t_d;
      f_q     <= f_d;
      h_q     <= h_d;
      idx_q   <= idx_d;
    end
  end

  assign bus.in_ready  = (state_q == S_FILL);
  assign bus.blk_valid = (state_q == S_EMIT) && !bus.start;
  assign bus.m_out     = blk_q;
  assign bus.t_out     = t_q;
  assign bus.f_out     = f_q;
  assign bus.out_valid = (state_q == S_OUT) && !bus.start;
  assign bus.out_data  = (state_q == S_OUT) ? h_q[8*idx_q +: 8] : 8'h00;
  assign bus.out_last  = bus.out_valid && idx_last;
  assign bus.busy      = (state_q != S_IDLE);
endmodule

// File: tb/tb_msg_blocker.sv
// Directed bench: one W=32/IB=4 blocker and one W=64/IB=8/OUT_LEN=32 blocker driven in turn.
module tb_msg_blocker;
  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  msg_blocker_if #(.W(32), .IB(4)) a ();
  msg_blocker_if #(.W(64), .IB(8)) b ();

  msg_blocker #(.W(32), .IB(4)) dut_a (.clk(clk), .rst_n(rst_n), .bus(a));
  msg_blocker #(.W(64), .IB(8), .OUT_LEN(32)) dut_b (.clk(clk), .rst_n(rst_n), .bus(b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_a(input logic [31:0] data, input logic [2:0] nb, input logic last);
    check("a_in_ready_before_beat", a.in_ready, 1);
    a.in_valid  = 1'b1;
    a.in_data   = data;
    a.in_nbytes = nb;
    a.in_last   = last;
    tick();
    a.in_valid  = 1'b0;
    a.in_last   = 1'b0;
    a.in_nbytes = '0;
  endtask

  logic [1023:0] exp_v;
  logic [31:0]   beat;
  int            idx;
  int            cyc;
  logic          rdy;

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b1;
    a.start = 0; a.in_data = '0; a.in_nbytes = '0; a.in_valid = 0; a.in_last = 0;
    a.blk_ready = 0; a.h_in = '0; a.h_valid = 0; a.out_ready = 0;
    b.start = 0; b.in_data = '0; b.in_nbytes = '0; b.in_valid = 0; b.in_last = 0;
    b.blk_ready = 0; b.h_in = '0; b.h_valid = 0; b.out_ready = 0;

    // Reset values
    #2 rst_n = 1'b0;
    tick(); tick();
    check("rst_busy",      a.busy, 0);
    check("rst_in_ready",  a.in_ready, 0);
    check("rst_blk_valid", a.blk_valid, 0);
    check("rst_out_valid", a.out_valid, 0);
    check("rst_out_last",  a.out_last, 0);
    check("rst_t_out",     a.t_out, 0);
    check("rst_f_out",     a.f_out, 0);
    check("rst_m_out",     a.m_out, 0);
    check("rst_out_data",  a.out_data, 0);
    check("rst_b_busy",    b.busy, 0);

    // start held across the first two edges after release must be ignored
    rst_n   = 1'b1;
    a.start = 1'b1;
    tick();
    check("sync_edge1_busy", a.busy, 0);
    tick();
    check("sync_edge2_busy", a.busy, 0);
    a.start = 1'b0;
    tick();
    check("sync_idle", a.busy, 0);

    // "abc" as three one-byte beats, with a stray h_valid in FILL
    a.start = 1'b1; tick(); a.start = 1'b0;
    check("abc_fill_busy", a.busy, 1);
    a.h_valid = 1'b1; a.h_in = {256{1'b1}}; tick(); a.h_valid = 1'b0;
    check("hvalid_ignored_fill", a.in_ready, 1);
    check("hvalid_ignored_outv", a.out_valid, 0);
    send_a(32'h61, 3'd1, 1'b0);
    send_a(32'h62, 3'd1, 1'b0);
    send_a(32'h63, 3'd1, 1'b1);
    check("abc_blk_valid", a.blk_valid, 1);
    check("abc_m_out", a.m_out, 1024'h636261);
    check("abc_t_out", a.t_out, 3);
    check("abc_f_out", a.f_out, 1);
    check("abc_in_ready", a.in_ready, 0);
    a.blk_ready = 1'b1; tick(); a.blk_ready = 1'b0;
    check("abc_wait_blk_valid", a.blk_valid, 0);
    check("abc_wait_busy", a.busy, 1);

    // Digest stream aborted by start after 5 bytes
    for (int i = 0; i < 32; i++) a.h_in[8*i +: 8] = 8'(8'h40 + i);
    a.h_valid = 1'b1; tick(); a.h_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("abort_out_valid", a.out_valid, 1);
      check("abort_out_data", a.out_data, 8'h40 + i);
      a.out_ready = 1'b1; tick();
    end
    a.out_ready = 1'b0;
    check("abort_held_byte", a.out_data, 8'h45);
    a.start = 1'b1; tick(); a.start = 1'b0;
    check("abort_out_valid_low", a.out_valid, 0);
    check("abort_in_fill", a.in_ready, 1);
    check("abort_t_zero", a.t_out, 0);
    check("abort_busy", a.busy, 1);

    // 128-byte message: two full blocks, last one final
    for (int j = 0; j < 16; j++) begin
      beat = {8'(4*j+3), 8'(4*j+2), 8'(4*j+1), 8'(4*j)};
      send_a(beat, 3'd4, 1'b0);
    end
    exp_v = '0;
    for (int i = 0; i < 64; i++) exp_v[8*i +: 8] = 8'(i);
    check("blk1_valid", a.blk_valid, 1);
    check("blk1_m_out", a.m_out, exp_v);
    check("blk1_t_out", a.t_out, 64);
    check("blk1_f_out", a.f_out, 0);
    for (int c = 0; c < 10; c++) begin
      tick();
      check("stall_blk_valid", a.blk_valid, 1);
      check("stall_in_ready", a.in_ready, 0);
      check("stall_m_out", a.m_out, exp_v);
      check("stall_t_out", a.t_out, 64);
    end
    a.blk_ready = 1'b1; tick(); a.blk_ready = 1'b0;
    check("blk1_done_valid", a.blk_valid, 0);
    for (int j = 16; j < 32; j++) begin
      beat = {8'(4*j+3), 8'(4*j+2), 8'(4*j+1), 8'(4*j)};
      send_a(beat, 3'd4, (j == 31));
    end
    exp_v = '0;
    for (int i = 0; i < 64; i++) exp_v[8*i +: 8] = 8'(64 + i);
    check("blk2_valid", a.blk_valid, 1);
    check("blk2_m_out", a.m_out, exp_v);
    check("blk2_t_out", a.t_out, 128);
    check("blk2_f_out", a.f_out, 1);
    a.blk_ready = 1'b1; tick(); a.blk_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check("no_third_block", a.blk_valid, 0);
      check("wait_h_busy", a.busy, 1);
      tick();
    end

    // Digest with out_ready toggling every other cycle
    for (int i = 0; i < 32; i++) a.h_in[8*i +: 8] = 8'(8'h80 + i);
    a.h_valid = 1'b1; tick(); a.h_valid = 1'b0;
    idx = 0;
    cyc = 0;
    while (idx < 32 && cyc < 200) begin
      rdy = cyc[0];
      a.out_ready = rdy;
      if (a.out_valid) begin
        check("tog_out_data", a.out_data, 8'h80 + idx);
        check("tog_out_last", a.out_last, (idx == 31));
        if (rdy) idx++;
      end
      tick();
      cyc++;
    end
    a.out_ready = 1'b0;
    check("tog_byte_count", idx, 32);
    check("tog_idle_busy", a.busy, 0);
    check("tog_idle_out_valid", a.out_valid, 0);

    // W=64 empty message, 32-byte digest
    b.start = 1'b1; tick(); b.start = 1'b0;
    check("b_in_ready", b.in_ready, 1);
    b.in_valid = 1'b1; b.in_nbytes = '0; b.in_last = 1'b1; b.in_data = '0;
    tick();
    b.in_valid = 1'b0; b.in_last = 1'b0;
    check("empty_blk_valid", b.blk_valid, 1);
    check("empty_m_out", b.m_out, 0);
    check("empty_t_out", b.t_out, 0);
    check("empty_f_out", b.f_out, 1);
    b.blk_ready = 1'b1; tick(); b.blk_ready = 1'b0;
    for (int i = 0; i < 64; i++) b.h_in[8*i +: 8] = 8'(i);
    b.h_valid = 1'b1; tick(); b.h_valid = 1'b0;
    b.out_ready = 1'b1;
    idx = 0;
    cyc = 0;
    while (idx < 32 && cyc < 100) begin
      if (b.out_valid) begin
        check("b_out_data", b.out_data, idx);
        check("b_out_last", b.out_last, (idx == 31));
        idx++;
      end
      tick();
      cyc++;
    end
    b.out_ready = 1'b0;
    check("b_byte_count", idx, 32);
    check("b_idle_busy", b.busy, 0);

    // Reset pulse in EMIT takes effect without a clock edge
    a.start = 1'b1; tick(); a.start = 1'b0;
    send_a(32'h78, 3'd1, 1'b1);
    check("pre_rst_blk_valid", a.blk_valid, 1);
    rst_n = 1'b0;
    #1;
    check("async_rst_blk_valid", a.blk_valid, 0);
    check("async_rst_busy", a.busy, 0);
    check("async_rst_m_out", a.m_out, 0);
    check("async_rst_t_out", a.t_out, 0);
    check("async_rst_f_out", a.f_out, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/msg_blocker.md
MSG_BLOCKER -- requirements
Module: msg_blocker

Interface
REQ-001 Parameter W, default 32, meaning hash word width in bits (32 or 64); block is BB=2*W bytes, state is W bytes.
REQ-002 Parameter IB, default 1, meaning input bytes per beat (power of 2, 1..8, divides BB).
REQ-003 Parameter OUT_LEN, default W, meaning digest bytes emitted (1..W).
REQ-004 clk  in  1  sole clock, all state on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  one-cycle pulse, begins (or aborts and restarts) a message.
REQ-007 in_data  in  8*IB  message bytes, byte k at bits [8k+:8].
REQ-008 in_nbytes  in  clog2(IB+1)  valid bytes in beat, low-aligned; 0 only legal with in_last.
REQ-009 in_valid / in_ready  in / out  1  input handshake, transfer when both high.
REQ-010 in_last  in  1  beat is final beat of message.
REQ-011 blk_valid / blk_ready  out / in  1  block handshake to compressor.
REQ-012 m_out  out  8*BB  block, byte i at bits [8i+:8], unused bytes zero.
REQ-013 t_out  out  2*W  total bytes consumed including this block.
REQ-014 f_out  out  1  final-block flag.
REQ-015 h_in / h_valid  in / in  8*W / 1  chaining value from compressor, one-cycle valid.
REQ-016 out_data / out_valid / out_ready / out_last  out/out/in/out  8/1/1/1  digest byte stream.
REQ-017 busy  out  1  high whenever state is not IDLE.

Function
REQ-018 States SHALL be IDLE, FILL, EMIT, WAIT_H, OUT.
REQ-019 IDLE: start -> FILL with buffer, byte count cnt, t and final flag cleared.
REQ-020 in_ready SHALL equal (state==FILL); beats outside FILL are not accepted.
REQ-021 Accepted beat SHALL write in_nbytes bytes at buffer bytes cnt..cnt+nbytes-1, cnt+=nbytes, t+=nbytes (2W-bit, wraps modulo 2^(2W)).
REQ-022 FILL -> EMIT the cycle after a beat makes cnt==BB, or after any in_last beat; f latched = in_last.
REQ-023 EMIT: blk_valid high, m_out/t_out/f_out stable until blk_ready; on handshake buffer and cnt clear.
REQ-024 EMIT handshake with f=0 -> FILL; with f=1 -> WAIT_H.
REQ-025 Full non-last block SHALL be emitted f=0; message of exact multiple of BB ends with in_last beat filling buffer, giving f=1 on that block, never an extra empty block.
REQ-026 Empty message (in_last, nbytes=0, cnt=0) SHALL emit one all-zero block, t=0, f=1.
REQ-027 h_valid outside WAIT_H SHALL be ignored.
REQ-028 WAIT_H + h_valid: latch h_in, byte index=0, -> OUT.
REQ-029 OUT: out_data = latched byte [index], out_valid high; on out_ready index++, out_last high when index==OUT_LEN-1; handshake on last byte -> IDLE.
REQ-030 start in any non-IDLE state SHALL abort: same clearing as REQ-019, -> FILL next cycle, no block or byte issued that cycle.
REQ-031 start and in_valid same cycle: beat not accepted (in_ready evaluated before start takes effect in following cycle only).

Reset
REQ-032 rst_n low SHALL immediately force IDLE, in_ready=0, blk_valid=0, out_valid=0, out_last=0, busy=0, t_out=0, f_out=0, m_out=0, out_data=0.
REQ-033 rst_n deassertion SHALL be synchronised internally; first state change no earlier than second clk edge after release.

Verification
REQ-034 W=32, IB=1: start, bytes "abc" with in_last on 'c' -> one block, m_out bytes 0..2 = 61 62 63 rest 0, t_out=3, f_out=1.
REQ-035 W=32, IB=4: 128 bytes, in_last on beat 32 -> two blocks, t_out=64 f=0 then t_out=128 f=1, no third block.
REQ-036 W=64, IB=8, OUT_LEN=32: empty message -> one zero block t=0 f=1; h_valid with h_in byte i = i -> 32 bytes 00..1F, out_last on 1F, then IDLE.
REQ-037 blk_ready held low 10 cycles in EMIT -> in_ready=0, m_out/t_out stable throughout; out_ready toggled every other cycle -> each byte held until accepted, none dropped.
REQ-038 start asserted mid-OUT after 5 bytes -> out_valid drops next cycle, state FILL, t=0; new message hashes correctly.
REQ-039 rst_n pulsed low mid-EMIT with no clk edge -> blk_valid and busy go low immediately.
